// File: rtl/formant_seg_dp_if.sv
// Stream/control bundle for the formant segmentation DP core.
// slave = the core, master = whoever feeds costs and drains boundaries.
interface formant_seg_dp_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int MAX_SEG   = 8
);
    localparam int IW = $clog2(I);
    localparam int KW = $clog2(MAX_SEG + 1);

    logic                 start;
    logic [KW-1:0]        num_seg;
    logic                 busy;
    logic                 cfg_err;

    logic                 cost_valid;
    logic                 cost_ready;
    logic [BIT_WIDTH-1:0] cost_data;

    logic                 bound_valid;
    logic                 bound_ready;
    logic [IW-1:0]        bound_data;
    logic                 bound_last;

    logic [BIT_WIDTH-1:0] total_cost;
    logic                 done;

    modport slave (
        input  start, num_seg,
        input  cost_valid, cost_data,
        input  bound_ready,
        output cost_ready, busy, cfg_err,
        output bound_valid, bound_data, bound_last,
        output total_cost, done
    );

    modport master (
        output start, num_seg,
        output cost_valid, cost_data,
        output bound_ready,
        input  cost_ready, busy, cfg_err,
        input  bound_valid, bound_data, bound_last,
        input  total_cost, done
    );
endinterface

// File: rtl/formant_seg_dp.sv
// Runtime-K dynamic-programming segmentation of I bins into contiguous
// segments; streams segment costs in, traces back and streams starts out.
module formant_seg_dp #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int MAX_SEG   = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    formant_seg_dp_if.slave  bus
);
    localparam int IW = $clog2(I);
    localparam int KW = $clog2(MAX_SEG + 1);
    localparam logic [IW-1:0] I_LAST = IW'(I - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_WRITE,
        S_TRACE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [BIT_WIDTH-1:0] f_mem [1:MAX_SEG][0:I-1];
    logic [IW-1:0]        b_mem [1:MAX_SEG][0:I-1];

    logic [KW-1:0]        k_q;
    logic [IW-1:0]        i_q;
    logic [IW-1:0]        j_q;
    logic [BIT_WIDTH-1:0] f1_q;

    logic                 p_val_q;
    logic [IW-1:0]        p_j_q;
    logic [BIT_WIDTH-1:0] p_e_q;
    logic [BIT_WIDTH-1:0] p_f_q [2:MAX_SEG];

    logic [BIT_WIDTH-1:0] run_min_q [2:MAX_SEG];
    logic [IW-1:0]        run_b_q   [2:MAX_SEG];
    logic [BIT_WIDTH-1:0] fin_min   [1:MAX_SEG];
    logic [IW-1:0]        fin_b     [1:MAX_SEG];

    logic [KW-1:0]        tk_q;
    logic [IW-1:0]        tb_q;
    logic                 tr_ph_q;
    logic [IW-1:0]        rd_b_q;
    logic [IW-1:0]        s_q [2:MAX_SEG];
    logic [KW-1:0]        e_k_q;

    logic [BIT_WIDTH-1:0] total_q;
    logic                 cfg_err_q;

    logic                 cfg_ok;
    logic                 cost_fire;
    logic [IW-1:0]        rd_addr;

    function automatic logic [BIT_WIDTH-1:0] sat_add(
        input logic [BIT_WIDTH-1:0] a,
        input logic [BIT_WIDTH-1:0] b
    );
        logic [BIT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[BIT_WIDTH] ? '1 : s[BIT_WIDTH-1:0];
    endfunction

    assign cfg_ok = (bus.num_seg != '0)
                 && (int'(bus.num_seg) <= MAX_SEG)
                 && (int'(bus.num_seg) <= I);

    assign cost_fire = bus.cost_valid && (state_q == S_ACCUM);
    assign rd_addr   = (j_q == '0) ? '0 : j_q - IW'(1);

    assign bus.cfg_err    = cfg_err_q;
    assign bus.total_cost = total_q;
    assign bus.bound_data = (state_q == S_EMIT) ? s_q[e_k_q] : '0;
    assign bus.bound_last = (state_q == S_EMIT) && (e_k_q == k_q);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.cost_ready  = 1'b0;
        bus.bound_valid = 1'b0;
        bus.done        = 1'b0;
        bus.busy        = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && cfg_ok) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                bus.cost_ready = 1'b1;
                if (cost_fire && (j_q == i_q)) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = (i_q == I_LAST) ? S_TRACE : S_ACCUM;
            end
            S_TRACE: begin
                if (k_q == KW'(1)) begin
                    state_d = S_DONE;
                end else if (tr_ph_q && (tk_q == KW'(2))) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                bus.bound_valid = 1'b1;
                if (bus.bound_ready && (e_k_q == k_q)) state_d = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fold the pipelined beat into each running minimum; strict < keeps
    // the earliest j on ties since beats arrive in ascending j.
    always_comb begin
        fin_min[1] = f1_q;
        fin_b[1]   = '0;
        for (int k = 2; k <= MAX_SEG; k++) begin
            fin_min[k] = run_min_q[k];
            fin_b[k]   = run_b_q[k];
            if (p_val_q && (int'(p_j_q) >= k - 1)
                && (sat_add(p_f_q[k], p_e_q) < run_min_q[k])) begin
                fin_min[k] = sat_add(p_f_q[k], p_e_q);
                fin_b[k]   = p_j_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            k_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            f1_q      <= '0;
            p_val_q   <= 1'b0;
            tk_q      <= '0;
            tb_q      <= '0;
            tr_ph_q   <= 1'b0;
            e_k_q     <= '0;
            total_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == S_IDLE) && bus.start && !cfg_ok;
            p_val_q   <= cost_fire;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && cfg_ok) begin
                        k_q <= bus.num_seg;
                        i_q <= '0;
                        j_q <= '0;
                    end
                end
                S_ACCUM: begin
                    if (cost_fire) begin
                        if (j_q == '0) f1_q <= bus.cost_data;
                        if (j_q == i_q) begin
                            j_q <= '0;
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (i_q == I_LAST) begin
                        tk_q    <= k_q;
                        tb_q    <= I_LAST;
                        tr_ph_q <= 1'b0;
                        e_k_q   <= KW'(2);
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                S_TRACE: begin
                    total_q <= f_mem[k_q][I_LAST];
                    tr_ph_q <= ~tr_ph_q;
                    if (tr_ph_q) begin
                        tb_q <= rd_b_q - IW'(1);
                        tk_q <= tk_q - KW'(1);
                    end
                end
                S_EMIT: begin
                    if (bus.bound_ready) e_k_q <= e_k_q + KW'(1);
                end
                default: ;
            endcase
        end
    end

    // Tables and per-beat pipeline carry no reset; each entry is written
    // before it is read within a frame.
    always_ff @(posedge clk_in) begin
        if (cost_fire) begin
            p_j_q <= j_q;
            p_e_q <= bus.cost_data;
            for (int k = 2; k <= MAX_SEG; k++) begin
                p_f_q[k] <= f_mem[k-1][rd_addr];
            end
        end
        if ((state_q == S_IDLE) || (state_q == S_WRITE)) begin
            for (int k = 2; k <= MAX_SEG; k++) begin
                run_min_q[k] <= '1;
                run_b_q[k]   <= IW'(k - 1);
            end
        end else if (state_q == S_ACCUM) begin
            for (int k = 2; k <= MAX_SEG; k++) begin
                run_min_q[k] <= fin_min[k];
                run_b_q[k]   <= fin_b[k];
            end
        end
        if (state_q == S_WRITE) begin
            for (int k = 1; k <= MAX_SEG; k++) begin
                if (k <= int'(k_q)) begin
                    f_mem[k][i_q] <= fin_min[k];
                    b_mem[k][i_q] <= fin_b[k];
                end
            end
        end
        if (state_q == S_TRACE) begin
            if (!tr_ph_q) begin
                rd_b_q <= b_mem[tk_q][tb_q];
            end else begin
                s_q[tk_q] <= rd_b_q;
            end
        end
    end
endmodule

// File: tb/tb_formant_seg_dp.sv
// Randomised bench for formant_seg_dp against a plain-arithmetic DP model.
// Small geometry (I=4, MAX_SEG=5) keeps frames short and reaches the K>I path.
module tb_formant_seg_dp;
    localparam int BW   = 32;
    localparam int TI   = 4;
    localparam int TMAX = 5;
    localparam int IW   = $clog2(TI);
    localparam int KW   = $clog2(TMAX + 1);
    localparam longint INF = 64'h0000_0000_FFFF_FFFF;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    formant_seg_dp_if #(.BIT_WIDTH(BW), .I(TI), .MAX_SEG(TMAX)) bus();

    formant_seg_dp #(.BIT_WIDTH(BW), .I(TI), .MAX_SEG(TMAX)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    longint e_tab [0:TI-1][0:TI-1];
    longint fm    [1:TMAX][0:TI-1];
    int     bm    [1:TMAX][0:TI-1];
    int     exp_q[$];
    longint exp_total;
    int     got_q[$];
    longint got_total;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // F(1,i)=E(0,i); F(k,i)=min_j F(k-1,j-1)+E(j,i), first minimal j wins.
    task automatic model(input int kk);
        longint best, c;
        int bj, b;
        for (int i = 0; i < TI; i++) fm[1][i] = e_tab[0][i];
        for (int k = 2; k <= kk; k++) begin
            for (int i = 0; i < TI; i++) begin
                best = INF;
                bj   = k - 1;
                for (int j = k - 1; j <= i; j++) begin
                    c = fm[k-1][j-1] + e_tab[j][i];
                    if (c > INF) c = INF;
                    if (c < best) begin
                        best = c;
                        bj   = j;
                    end
                end
                fm[k][i] = best;
                bm[k][i] = bj;
            end
        end
        exp_total = fm[kk][TI-1];
        exp_q.delete();
        b = TI - 1;
        for (int k = kk; k >= 2; k--) begin
            exp_q.push_front(bm[k][b]);
            b = bm[k][b] - 1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {bus.busy, bus.cost_ready, bus.cfg_err,
                            bus.bound_valid, bus.bound_last, bus.done}, 0);
        chk({tag, "_bdata"}, bus.bound_data, 0);
        chk({tag, "_total"}, bus.total_cost, 0);
    endtask

    task automatic start_frame(input int kk);
        bus.start   = 1'b1;
        bus.num_seg = KW'(kk);
        @(negedge clk_in);
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_cfg_err", bus.cfg_err, 0);
    endtask

    task automatic cfg_bad(input int ns);
        bus.start   = 1'b1;
        bus.num_seg = KW'(ns);
        @(negedge clk_in);
        bus.start = 1'b0;
        chk("cfg_err_pulse", bus.cfg_err, 1);
        chk("cfg_busy", bus.busy, 0);
        chk("cfg_ready", bus.cost_ready, 0);
        @(negedge clk_in);
        chk("cfg_err_clear", bus.cfg_err, 0);
        chk("cfg_busy_after", bus.busy, 0);
    endtask

    task automatic send_beat(input int j, input int i, input int gap_max);
        int n = 0;
        bus.cost_valid = 1'b1;
        bus.cost_data  = e_tab[j][i][BW-1:0];
        while (!bus.cost_ready && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk("cost_ready_wait", n >= 50, 0);
        @(negedge clk_in);
        bus.cost_valid = 1'b0;
        bus.cost_data  = $urandom;
        if (j == i) begin
            chk("ready_low_write", bus.cost_ready, 0);
            @(negedge clk_in);
            chk("ready_after_write", bus.cost_ready, i < TI - 1);
        end else if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk_in);
        end
    endtask

    task automatic recv(input bit stall);
        int stall_idx;
        int stalled = 0;
        int dones = 0;
        logic [IW-1:0] held = '0;
        bit fin = 1'b0;
        got_q.delete();
        got_total = 0;
        stall_idx = (exp_q.size() > 1) ? 1 : 0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (bus.done) begin
                dones++;
                got_total = bus.total_cost;
                fin = 1'b1;
            end else begin
                if (bus.bound_valid && stall && got_q.size() == stall_idx
                    && stalled < 5) begin
                    if (stalled == 0) held = bus.bound_data;
                    else chk("stall_hold", bus.bound_data, held);
                    stalled++;
                    bus.bound_ready = 1'b0;
                end else if (bus.bound_valid) begin
                    bus.bound_ready = ($urandom_range(0, 3) != 0);
                    if (bus.bound_ready) begin
                        got_q.push_back(int'(bus.bound_data));
                        chk("bound_last", bus.bound_last,
                            got_q.size() == exp_q.size());
                    end
                end else begin
                    bus.bound_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk_in);
            end
        end
        bus.bound_ready = 1'b0;
        chk("done_seen", dones, 1);
        @(negedge clk_in);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    task automatic run_frame(input int kk, input int gap_max, input bit stall);
        model(kk);
        start_frame(kk);
        for (int i = 0; i < TI; i++) begin
            for (int j = 0; j <= i; j++) send_beat(j, i, gap_max);
        end
        recv(stall);
        chk("total_cost", got_total, exp_total);
        chk("n_bounds", got_q.size(), exp_q.size());
        for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
            chk("bound_start", got_q[n], exp_q[n]);
        end
    endtask

    task automatic fill(input longint v);
        for (int i = 0; i < TI; i++)
            for (int j = 0; j < TI; j++) e_tab[j][i] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.num_seg     = '0;
        bus.cost_valid  = 1'b0;
        bus.cost_data   = '0;
        bus.bound_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_reset("rst_init");
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_reset("rst_idle");

        for (int i = 0; i < TI; i++)
            for (int j = 0; j < TI; j++) e_tab[j][i] = 10 * (i - j);
        e_tab[0][1] = 0;
        e_tab[2][3] = 0;
        run_frame(2, 0, 1'b0);
        chk("basic_total", got_total, 0);
        chk("basic_n", got_q.size(), 1);
        if (got_q.size() > 0) chk("basic_s2", got_q[0], 2);

        fill(0);
        run_frame(3, 1, 1'b0);
        chk("tie_total", got_total, 0);
        chk("tie_n", got_q.size(), 2);
        if (got_q.size() > 1) begin
            chk("tie_s2", got_q[0], 1);
            chk("tie_s3", got_q[1], 2);
        end

        for (int i = 0; i < TI; i++)
            for (int j = 0; j < TI; j++) e_tab[j][i] = $urandom_range(0, 50);
        e_tab[0][3] = 7;
        run_frame(1, 2, 1'b0);
        chk("k1_total", got_total, 7);
        chk("k1_n", got_q.size(), 0);

        cfg_bad(0);
        cfg_bad(TMAX + 1);
        cfg_bad(TI + 1);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < TI; i++)
                for (int j = 0; j < TI; j++)
                    e_tab[j][i] = (f % 2) ? longint'($urandom)
                                          : longint'($urandom_range(0, 15));
            run_frame($urandom_range(1, TI), 3, 1'b1);
        end

        fill(INF);
        run_frame(2, 1, 1'b1);
        chk("sat_total", got_total, INF);

        for (int i = 0; i < TI; i++)
            for (int j = 0; j < TI; j++) e_tab[j][i] = $urandom_range(0, 99);
        start_frame(3);
        send_beat(0, 0, 0);
        send_beat(0, 1, 0);
        send_beat(1, 1, 0);
        send_beat(0, 2, 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk_reset("rst_mid");
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_reset("rst_mid_idle");
        run_frame(3, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
